serial_subtractor: RTL and testbench

//   Bit-serial unsigned subtractor, computes a - b LSB-first.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock, start/done handshake.
// Optional build macro SERIAL_SUB_SAT_EN: clamp diff to zero when the final borrow is set.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             br,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  // Holds the WIDTH-1 bits already produced; the final bit comes straight from the cell.
  logic [WIDTH-2:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;

  logic             cell_x, cell_y;
  logic             cell_diff, cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] diff_load;

  always_comb begin
    cell_x    = sa_q[0];
    cell_y    = sb_q[0];
    cell_diff = cell_x ^ cell_y ^ bor_q;
    cell_bout = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & bor_q);
    last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
    res_full  = {cell_diff, res_q};
  end

`ifdef SERIAL_SUB_SAT_EN
  always_comb diff_load = cell_bout ? '0 : res_full;
`else
  always_comb diff_load = res_full;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    diff = diff_q;
    br   = br_q;
  end

  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    res_d  = res_q;
    bor_d  = bor_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    br_d   = br_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d  = a;
          sb_d  = b;
          res_d = '0;
          bor_d = 1'b0;
          cnt_d = '0;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = (WIDTH-1)'(res_full >> 1);
        bor_d = cell_bout;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          diff_d = diff_load;
          br_d   = cell_bout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q   <= '0;
      sb_q   <= '0;
      res_q  <= '0;
      bor_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      res_q  <= res_d;
      bor_q  <= bor_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      br_q   <= br_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic [7:0] diff;
  logic       br, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
  } vec_t;

  vec_t vt[10];

  serial_subtractor #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .br    (br),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] d, input logic bo);
`ifdef SERIAL_SUB_SAT_EN
    return bo ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  // Issue one op from IDLE and check latency, busy span, result, hold and done width.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                        input logic [7:0] ed, input logic ebr, input string nm);
    int n, bc;
    logic [7:0] held_d;
    logic       held_br;
    bit         unstable;
    @(negedge clk); a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    held_d = diff; held_br = br; unstable = 0; n = 0; bc = 0;
    @(negedge clk); start = 1'b0;
    #4;
    forever begin
      if (busy) bc++;
      if (done || n >= 40) break;
      if (diff !== held_d || br !== held_br) unstable = 1;
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, n, 8);
    chk({nm, "_busy_cycles"}, bc, 9);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_br"}, br, ebr);
    chk({nm, "_held_during_run"}, unstable, 0);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int n;
    bit seen;
    logic [7:0] ra, rb, ed;
    logic       ebr;

    vt[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
    vt[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vt[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vt[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vt[5] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    vt[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vt[8] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
    vt[9] = '{8'h10, 8'h20, 8'hF0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_diff", diff, 0);
    chk("reset_br", br, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vt[i].a, vt[i].b, sat(vt[i].d, vt[i].br), vt[i].br, $sformatf("vec%0d", i));

    // start held high, operands change mid-run
    @(negedge clk); a = 8'h50; b = 8'h20; start = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy_accept", busy, 1);
    @(negedge clk); a = 8'hFF; b = 8'h00;
    n = 0;
    #4;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("hold_latency", n, 8);
    chk("hold_diff", diff, 8'h30);
    chk("hold_br", br, 0);
    @(posedge clk); #1;
    chk("hold_no_queue", busy, 0);
    chk("hold_done_low", done, 0);
    @(posedge clk); #1;
    chk("hold_reaccept", busy, 1);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_diff_stable_next_run", diff, 8'h30);
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("hold_second_diff", diff, 8'hFF);
    chk("hold_second_br", br, 0);
    @(posedge clk); #1;

    // reset three cycles into RUN
    @(negedge clk); a = 8'h12; b = 8'h35; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_br", br, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) seen = 1; end
    chk("abort_no_done", seen, 0);
    run_op(8'h35, 8'h12, 8'h23, 1'b0, "after_abort");

    // reset and start on the same edge
    @(negedge clk); rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    chk("rst_beats_start_busy", busy, 0);
    chk("rst_beats_start_diff", diff, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_beats_start_idle", busy, 0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      {ebr, ed} = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, sat(ed, ebr), ebr, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
